mem_port_arbiter: RTL

- Round-robin arbiter sharing the single memory port among NCORES cores. Cores present read or write requests; the arbiter issues one access per cycle and routes read data back to the granted core with a tagged valid.
- Sits between the per-core memRead/memWrite interfaces and the shared mem array. Replaces the free-for-all multi-writer loop with one serialized port.

---
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that serializes NCORES core requests onto a single memory port,
// returning read data tagged with the owning core ID. Optional lock ownership via MEM_ARB_LOCK_EN.
module mem_port_arbiter #(
    parameter int NCORES = 16,
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int IDW    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCORES-1:0]  req,
    input  logic [NCORES-1:0]  we,
    input  logic [NCORES*AW-1:0] addr,
    input  logic [NCORES*DW-1:0] wdata,
    input  logic [NCORES-1:0]  lock,
    output logic [NCORES-1:0]  gnt,
    output logic               mem_en,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    input  logic [DW-1:0]      mem_rdata,
    output logic               rvalid,
    output logic [IDW-1:0]     rid,
    output logic [DW-1:0]      rdata
);

    localparam logic [NCORES-1:0] ONE_HOT_BASE = {{(NCORES-1){1'b0}}, 1'b1};

    logic [IDW-1:0]    ptr_r;
    logic [IDW-1:0]    winner_s;
    logic              anyGnt_s;
    logic [NCORES-1:0] reqEff_s;

`ifdef MEM_ARB_LOCK_EN
    logic              ownerValid_r;
    logic [IDW-1:0]    owner_r;
`else
    logic              unusedLock_s;
    assign unusedLock_s = ^lock;
`endif

    // Qualify requests: nothing is granted in reset, and a lock owner excludes everyone else.
    always_comb begin
        reqEff_s = rst ? {NCORES{1'b0}} : req;
`ifdef MEM_ARB_LOCK_EN
        if (ownerValid_r) begin
            reqEff_s = reqEff_s & (ONE_HOT_BASE << owner_r);
        end else begin
            reqEff_s = reqEff_s;
        end
`endif
    end

    // Search downward so the last hit is the first requester at or after ptr (modulo NCORES).
    always_comb begin
        logic [IDW-1:0] idx;
        idx      = {IDW{1'b0}};
        winner_s = {IDW{1'b0}};
        anyGnt_s = 1'b0;
        for (int k = NCORES - 1; k >= 0; k--) begin
            idx      = ptr_r + IDW'(k);
            winner_s = reqEff_s[idx] ? idx : winner_s;
            anyGnt_s = anyGnt_s | reqEff_s[idx];
        end
    end

    // Memory port mux, forced to zero when idle.
    always_comb begin
        gnt       = anyGnt_s ? (ONE_HOT_BASE << winner_s) : {NCORES{1'b0}};
        mem_en    = anyGnt_s;
        mem_we    = anyGnt_s & we[winner_s];
        mem_addr  = anyGnt_s ? addr[int'(winner_s)*AW +: AW] : {AW{1'b0}};
        mem_wdata = anyGnt_s ? wdata[int'(winner_s)*DW +: DW] : {DW{1'b0}};
        rdata     = rvalid ? mem_rdata : {DW{1'b0}};
    end

    // Rotate pointer past the winner and tag the read return one cycle after issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r  <= {IDW{1'b0}};
            rvalid <= 1'b0;
            rid    <= {IDW{1'b0}};
        end else begin
            if (anyGnt_s) begin
                ptr_r <= winner_s + IDW'(1);
            end else begin
                ptr_r <= ptr_r;
            end
            rvalid <= anyGnt_s & ~we[winner_s];
            if (anyGnt_s && !we[winner_s]) begin
                rid <= winner_s;
            end else begin
                rid <= rid;
            end
        end
    end

`ifdef MEM_ARB_LOCK_EN
    // Under ownership every grant goes to the owner, so the lock bit at issue decides retention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ownerValid_r <= 1'b0;
            owner_r      <= {IDW{1'b0}};
        end else if (anyGnt_s) begin
            ownerValid_r <= lock[winner_s];
            owner_r      <= winner_s;
        end else begin
            ownerValid_r <= ownerValid_r;
            owner_r      <= owner_r;
        end
    end
`endif

endmodule
